spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by the system clock.
// The SPI pins pass through 2-flop synchronizers plus an edge-detect stage.
// The shifters and the FSM all run in the clk domain, so spi_clk must stay
// high and low for at least 4 clk periods each.
// A one-word holding register supplies the next transmit word. A strobe
// reports each finished transaction.
module spi_slave #(
  parameter int TX_BITS = 8,
  parameter int RX_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 spi_clk,
  input  logic                                 spi_cs,
  input  logic                                 spi_mosi,
  output logic                                 spi_miso,
  output logic                                 spi_miso_oe,
  input  logic [TX_BITS-1:0]                   tx_data,
  input  logic                                 stb_wr,
  output logic                                 tx_full,
  output logic [RX_BITS-1:0]                   rx_data,
  output logic [$clog2(TX_BITS+RX_BITS):0]     rx_len,
  output logic                                 stb_rdy,
  output logic                                 tx_underrun
);

  localparam int LEN_W = $clog2(TX_BITS + RX_BITS) + 1;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t             state;
  logic [2:0]         cs_sync;    // [0] first flop, [2] edge-detect stage
  logic [2:0]         sclk_sync;
  logic [1:0]         mosi_sync;
  logic [1:0]         settle;     // counts the synchronizer flush after reset
  logic [TX_BITS-1:0] hold;
  logic [TX_BITS-1:0] tx_sh;
  logic [RX_BITS-1:0] rx_sh;
  logic [LEN_W-1:0]   bit_cnt;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;

  // Synchronize the SPI pins, resetting to the idle bus levels (cs high, clk low).
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[1:0], spi_cs};
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  // Compare the second and third stages. mosi_sync[1] is the same age as
  // sclk_sync[1], so it holds the bit the master put up for this edge.
  assign cs_fall   =  cs_sync[2]   & ~cs_sync[1];
  assign cs_rise   = ~cs_sync[2]   &  cs_sync[1];
  assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
  assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];
  assign mosi_s    =  mosi_sync[1];

  // MISO is driven only while a transaction is active.
  assign spi_miso = spi_miso_oe & tx_sh[TX_BITS-1];

  // Transaction FSM together with its shifters, holding register and status flags.
  // NOTE: every register here, including the data holding register, is reset so
  // that nothing leaks out of the pads or status ports right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_IDLE;
      settle      <= '0;
      hold        <= '0;
      tx_full     <= 1'b0;
      tx_underrun <= 1'b0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_len      <= '0;
      stb_rdy     <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      stb_rdy <= 1'b0;
      if (settle != 2'd3) settle <= settle + 2'd1;

      case (state)
        // Until the synchronizers have flushed their reset values, cs reads
        // high no matter what the pin is doing. Waiting for a real cs-high
        // lets any transaction in flight at reset release pass unanswered.
        WAIT_IDLE: begin
          if (settle == 2'd3 && cs_sync[2]) state <= IDLE;
        end

        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            spi_miso_oe <= 1'b1;
            tx_sh       <= tx_full ? hold : '0;
            if (!tx_full) tx_underrun <= 1'b1;
            tx_full     <= 1'b0;
            rx_sh       <= '0;
            bit_cnt     <= '0;
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            state       <= DONE;
            spi_miso_oe <= 1'b0;
            tx_sh       <= '0;
            rx_data     <= rx_sh;
            rx_len      <= bit_cnt;
            stb_rdy     <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_sh <= (rx_sh << 1) | RX_BITS'(mosi_s);
              if (bit_cnt != '1) bit_cnt <= bit_cnt + LEN_W'(1);
            end
            if (sclk_fall) tx_sh <= tx_sh << 1;
          end
        end

        DONE: state <= IDLE;

        default: state <= WAIT_IDLE;
      endcase

      // Placed after the FSM, so a write coinciding with the load overrides the
      // load's tx_full clear. The new word waits for the next transaction.
      if (stb_wr) begin
        hold        <= tx_data;
        tx_full     <= 1'b1;
        tx_underrun <= 1'b0;
      end
    end
  end

endmodule
